// File: rtl/clint_timer_pkg.sv
// Shared definitions for the CLINT-style machine timer: register map,
// bus FSM encoding, reset values and the byte-strobe merge helper.
package clint_timer_pkg;

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_MSIP        = 3'd4;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

  function automatic logic [31:0] merge_strb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/clint_tick.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the last cycle of each period.
module clint_tick
  import clint_timer_pkg::*;
#(
  parameter int TICK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // With TICK_DIV=1 the counter is pinned at 0 and tick is constant high.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer: mtime/mtimecmp/msip over a word bus with a
// two-state request/ready handshake; drives mtip and msip to the CSR block.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int TICK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        mtip,
  output logic        msip
);

  bus_state_t  state, state_next;
  logic        tick;
  logic [63:0] mtime, mtime_next;
  logic [63:0] mtimecmp, mtimecmp_next;
  logic        msip_q, msip_next;
  logic [31:0] rd_val;
  logic        capture, wr, rd;
  logic [2:0]  idx;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];

  clint_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign idx     = addr[4:2];
  assign capture = (state == IDLE) && req;
  assign wr      = capture && we;
  assign rd      = capture && !we;
  assign ready   = (state == ACK);
  assign msip    = msip_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_val = 32'h0;
    case (idx)
      REG_MTIME_LO:    rd_val = mtime[31:0];
      REG_MTIME_HI:    rd_val = mtime[63:32];
      REG_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      REG_MTIMECMP_HI: rd_val = mtimecmp[63:32];
      REG_MSIP:        rd_val = {31'h0, msip_q};
      default:         rd_val = 32'h0;
    endcase
  end

  // A write to either mtime half is based on the pre-tick value, so the
  // coinciding increment is dropped and the other half is left untouched.
  always_comb begin
    mtime_next    = tick ? mtime + 64'd1 : mtime;
    mtimecmp_next = mtimecmp;
    msip_next     = msip_q;
    if (wr) begin
      case (idx)
        REG_MTIME_LO:    mtime_next = {mtime[63:32], merge_strb(mtime[31:0], wdata, wstrb)};
        REG_MTIME_HI:    mtime_next = {merge_strb(mtime[63:32], wdata, wstrb), mtime[31:0]};
        REG_MTIMECMP_LO: mtimecmp_next[31:0]  = merge_strb(mtimecmp[31:0], wdata, wstrb);
        REG_MTIMECMP_HI: mtimecmp_next[63:32] = merge_strb(mtimecmp[63:32], wdata, wstrb);
        REG_MSIP:        if (wstrb[0]) msip_next = wdata[0];
        default:         ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mtime    <= 64'h0;
      mtimecmp <= MTIMECMP_RST;
      msip_q   <= 1'b0;
      mtip     <= 1'b0;
      rdata    <= 32'h0;
    end else begin
      state    <= state_next;
      mtime    <= mtime_next;
      mtimecmp <= mtimecmp_next;
      msip_q   <= msip_next;
      mtip     <= (mtime >= mtimecmp);
      if (rd) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed scenarios plus random bus
// traffic, compared against a cycle-level behavioural model of the timer.
module tb_clint_timer;

  localparam int TICK_DIV = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready, mtip, msip;

  clint_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .rdata (rdata),
    .ready (ready),
    .mtip  (mtip),
    .msip  (msip)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  longint unsigned ecount;
  logic [63:0]     m_time, m_cmp;
  logic            m_msip, m_mtip, m_ack;
  logic [31:0]     m_rdata;

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d,
                                               input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a / 4)
      0: return m_time[31:0];
      1: return m_time[63:32];
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {31'h0, m_msip};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_time = 64'h0; m_cmp = '1; m_msip = 0; m_mtip = 0; m_ack = 0; m_rdata = 0; ecount = 0;
  endtask

  // Advance one clock edge, applying the spec rules to the model.
  task automatic cycle();
    logic [63:0] nt, nc;
    logic        nm, wrote_time, tk;
    tk = (ecount % TICK_DIV) == TICK_DIV - 1;
    nt = tk ? m_time + 64'd1 : m_time;
    nc = m_cmp;
    nm = m_msip;
    wrote_time = 0;
    if (!m_ack && req) begin
      if (!we) m_rdata = model_read(addr);
      else case (addr / 4)
        0: nt = {m_time[63:32], bytes_merge(m_time[31:0], wdata, wstrb)};
        1: nt = {bytes_merge(m_time[63:32], wdata, wstrb), m_time[31:0]};
        2: nc[31:0]  = bytes_merge(m_cmp[31:0], wdata, wstrb);
        3: nc[63:32] = bytes_merge(m_cmp[63:32], wdata, wstrb);
        4: if (wstrb[0]) nm = wdata[0];
        default: ;
      endcase
    end
    @(posedge clk);
    m_mtip = (m_time >= m_cmp);
    m_ack  = !m_ack && req;
    m_time = nt; m_cmp = nc; m_msip = nm;
    ecount++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic r_rdy, output logic [31:0] r_data);
    we = w; addr = a; wdata = d; wstrb = s; req = 1;
    cycle();
    r_rdy = ready; r_data = rdata;
    req = 0;
    cycle();
  endtask

  task automatic test_reset();
    logic r; logic [31:0] d;
    do_reset();
    checks++; if (ready !== 1'b0 || mtip !== 1'b0 || msip !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got ready=%b mtip=%b msip=%b rdata=%h want 0", ready, mtip, msip, rdata);
    end
    we = 1; addr = 5'h08; wdata = 32'h5; wstrb = 4'hF; req = 1;
    cycle();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_pre_ack got %b want 1", ready); end
    rst = 1; req = 0; #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_abort_ready got %b want 0", ready); end
    model_reset();
    @(posedge clk); #1; rst = 0;
    bus(0, 5'h00, 0, 0, r, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mtime got %h want 0", d); end
    bus(0, 5'h08, 0, 0, r, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo got %h want ffffffff", d); end
    bus(0, 5'h0C, 0, 0, r, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi got %h want ffffffff", d); end
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL reset_mtip got %b want 0", mtip); end
  endtask

  task automatic test_tick_rate();
    do_reset();
    repeat (250) cycle();
    we = 0; addr = 5'h00; req = 1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL lat_pre got %b want 0", ready); end
    cycle();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b want 1", ready); end
    checks++; if (rdata !== 32'd10) begin errors++; $display("FAIL tick_rate got %0d want 10", rdata); end
    req = 0;
    cycle();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL lat_post got %b want 0", ready); end
  endtask

  task automatic test_wrap();
    logic r; logic [31:0] d; int n;
    bus(1, 5'h04, 32'h0, 4'hF, r, d);
    bus(1, 5'h00, 32'hFFFF_FFFF, 4'hF, r, d);
    n = 0;
    while (m_time[63:32] == 0 && n < 60) begin cycle(); n++; end
    bus(0, 5'h04, 0, 0, r, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL wrap_hi got %h want 1", d); end
    bus(0, 5'h00, 0, 0, r, d);
    checks++; if (d !== m_rdata || d > 32'd1) begin errors++; $display("FAIL wrap_lo got %h want %h", d, m_rdata); end
    bus(1, 5'h04, 32'hFFFF_FFFF, 4'hF, r, d);
    bus(1, 5'h00, 32'hFFFF_FFFF, 4'hF, r, d);
    n = 0;
    while (m_time[31:0] == 32'hFFFF_FFFF && n < 60) begin cycle(); n++; end
    bus(0, 5'h04, 0, 0, r, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap64_hi got %h want 0", d); end
  endtask

  task automatic test_compare();
    logic r; logic [31:0] d; int hit, rise, bad;
    bus(1, 5'h0C, 32'h0, 4'hF, r, d);
    bus(1, 5'h08, 32'd100, 4'hF, r, d);
    bus(1, 5'h00, 32'h0, 4'hF, r, d);
    bus(1, 5'h04, 32'h0, 4'hF, r, d);
    hit = -1; rise = -1; bad = 0;
    for (int i = 0; i < 3000 && (rise < 0 || i < rise + 3); i++) begin
      cycle();
      if (hit < 0 && m_time == 64'd100) hit = i;
      if (rise < 0 && mtip === 1'b1) rise = i;
      if (mtip !== m_mtip) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mtip_track got %0d mismatching cycles want 0", bad); end
    checks++; if (hit < 0 || rise != hit + 1) begin errors++; $display("FAIL mtip_rise got cycle %0d want %0d", rise, hit + 1); end
    bus(1, 5'h0C, 32'h1, 4'hF, r, d);
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL mtip_fall got %b want 0", mtip); end
  endtask

  task automatic test_strobe_priority();
    logic r; logic [31:0] d;
    bus(1, 5'h08, 32'h1122_3344, 4'hF, r, d);
    bus(1, 5'h08, 32'hAABB_CCDD, 4'b0101, r, d);
    bus(0, 5'h08, 0, 0, r, d);
    checks++; if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe got %h want 11bb33dd", d); end
    while ((ecount % TICK_DIV) != TICK_DIV - 1) cycle();
    bus(1, 5'h00, 32'h1234_5678, 4'hF, r, d);
    bus(0, 5'h00, 0, 0, r, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL write_vs_tick got %h want 12345678", d); end
  endtask

  task automatic test_misc();
    logic r; logic [31:0] d;
    bus(1, 5'h10, 32'hFFFF_FFFF, 4'hF, r, d);
    checks++; if (msip !== 1'b1) begin errors++; $display("FAIL msip_out got %b want 1", msip); end
    bus(0, 5'h13, 0, 0, r, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL msip_read got %h want 1", d); end
    bus(1, 5'h18, 32'hDEAD_BEEF, 4'hF, r, d);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL unmapped_wr_ready got %b want 1", r); end
    bus(0, 5'h18, 0, 0, r, d);
    checks++; if (r !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_rd got rdy=%b %h want 1 0", r, d); end
    bus(0, 5'h08, 0, 0, r, d);
    checks++; if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL unmapped_side got %h want 11bb33dd", d); end
  endtask

  task automatic test_back_to_back();
    we = 0; addr = 5'h10; req = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if (ready !== ((i % 2) == 0)) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", i, ready, (i % 2) == 0); end
    end
    req = 0;
    cycle();
  endtask

  task automatic test_random();
    logic r; logic [31:0] d; logic w;
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      bus(w, 5'($urandom_range(0, 31)), $urandom, 4'($urandom), r, d);
      checks++; if (r !== 1'b1 || (!w && d !== m_rdata)) begin
        errors++; $display("FAIL rand_txn[%0d] got rdy=%b %h want 1 %h", i, r, d, m_rdata);
      end
      checks++; if (mtip !== m_mtip || msip !== m_msip) begin
        errors++; $display("FAIL rand_irq[%0d] got mtip=%b msip=%b want %b %b", i, mtip, msip, m_mtip, m_msip);
      end
      repeat ($urandom_range(0, 3)) cycle();
    end
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_wrap();
    test_compare();
    test_strobe_priority();
    test_misc();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
